// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller.
//   DIV_W_DFLT       default width of divisor and half-period counter
//   DEFAULT_DIV_DFLT default half-period loaded at reset
//   state_t          controller states
package clk_div_pkg;

    localparam int DIV_W_DFLT       = 8;
    localparam int DEFAULT_DIV_DFLT = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PEND     = 2'd2,   // new divisor waiting for the next falling edge
        STOPPING = 2'd3    // finishing the high phase before parking low
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the config register bank (master) and the
// divider controller (slave).
//   enable       run request
//   div_valid    new divisor offered
//   div_value    requested half-period
//   div_ready    controller accepts a divisor this cycle
//   divided_clk  divided clock output
//   tick         one-cycle pulse in the cycle divided_clk toggles
//   div_err      one-cycle pulse after a zero divisor was rejected
//   running      controller is RUN, PEND or STOPPING
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic             div_valid;
    logic [DIV_W-1:0] div_value;
    logic             div_ready;
    logic             divided_clk;
    logic             tick;
    logic             div_err;
    logic             running;

    modport master (
        output enable, div_valid, div_value,
        input  div_ready, divided_clk, tick, div_err, running
    );

    modport slave (
        input  enable, div_valid, div_value,
        output div_ready, divided_clk, tick, div_err, running
    );
endinterface

// File: rtl/clk_div_ctrl_half_period_cnt.sv
// Half-period counter with terminal-count compare.
//   clk, reset  system clock, synchronous active-high reset
//   clear       force counter to 0 (highest priority)
//   inc         advance the counter; wraps to 0 on terminal count
//   limit       half-period N (>= 1); terminal count is N-1
//   tc          counter currently equals limit-1
module half_period_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [DIV_W-1:0] limit,
    output logic             tc
);
    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;

    // limit is never 0, so limit-1 cannot underflow
    assign tc = (count_reg == (limit - DIV_W'(1)));

    always_comb begin
        count_next = count_reg;
        if (clear || (inc && tc)) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a clock divider. Accepts new half-period values over
// a valid/ready handshake and applies them only on a falling edge of
// divided_clk; sequences start/stop so the output always parks low cleanly.
//   clk, reset  system clock, synchronous active-high reset
//   bus         clk_div_ctrl_if slave side (enable, divisor handshake, outputs)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_ctrl_if.slave  bus
);
    state_t           state_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pend_reg;
    logic             pend_vld_reg;
    logic             divided_clk_reg;
    logic             tick_reg;
    logic             div_err_reg;

    logic             div_ready;
    logic             xfer;
    logic             xfer_ok;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             tc;

    assign div_ready = (state_reg == IDLE) || (state_reg == RUN);
    assign xfer      = bus.div_valid && div_ready;
    assign xfer_ok   = xfer && (bus.div_value != '0);

    // The counter is held at 0 while idle and whenever a stop catches the
    // output low: the next run or the park must start from a clean phase.
    always_comb begin
        cnt_clear = 1'b1;
        case (state_reg)
            IDLE:      cnt_clear = 1'b1;
            RUN, PEND: cnt_clear = !bus.enable && !divided_clk_reg;
            STOPPING:  cnt_clear = !divided_clk_reg;
            default:   cnt_clear = 1'b1;
        endcase
    end
    assign cnt_inc = !cnt_clear;

    half_period_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (div_reg),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            div_reg         <= DIV_W'(DEFAULT_DIV);
            pend_reg        <= '0;
            pend_vld_reg    <= 1'b0;
            divided_clk_reg <= 1'b0;
            tick_reg        <= 1'b0;
            div_err_reg     <= 1'b0;
        end else begin
            tick_reg    <= 1'b0;
            div_err_reg <= xfer && (bus.div_value == '0);

            case (state_reg)
                IDLE: begin
                    divided_clk_reg <= 1'b0;
                    // A divisor captured during a stop lands here; a fresh
                    // transfer in the same cycle supersedes it.
                    if (pend_vld_reg) begin
                        div_reg      <= pend_reg;
                        pend_vld_reg <= 1'b0;
                    end
                    if (xfer_ok) begin
                        div_reg <= bus.div_value;
                    end
                    if (bus.enable) begin
                        state_reg <= RUN;
                    end
                end

                RUN, PEND: begin
                    if (xfer_ok) begin
                        pend_reg     <= bus.div_value;
                        pend_vld_reg <= 1'b1;
                        state_reg    <= PEND;
                    end
                    if (!bus.enable) begin
                        // Stop wins over a divisor update; a captured value
                        // stays pending and is applied once parked.
                        if (divided_clk_reg && tc) begin
                            divided_clk_reg <= 1'b0;
                            tick_reg        <= 1'b1;
                            state_reg       <= IDLE;
                        end else begin
                            state_reg <= STOPPING;
                        end
                    end else if (tc) begin
                        divided_clk_reg <= !divided_clk_reg;
                        tick_reg        <= 1'b1;
                        // Only the falling edge is a safe point to change N.
                        if (divided_clk_reg && pend_vld_reg) begin
                            div_reg      <= pend_reg;
                            pend_vld_reg <= 1'b0;
                            state_reg    <= RUN;
                        end
                    end
                end

                STOPPING: begin
                    if (!divided_clk_reg) begin
                        state_reg <= IDLE;
                    end else if (tc) begin
                        divided_clk_reg <= 1'b0;
                        tick_reg        <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.div_ready   = div_ready;
    assign bus.divided_clk = divided_clk_reg;
    assign bus.tick        = tick_reg;
    assign bus.div_err     = div_err_reg;
    assign bus.running     = (state_reg != IDLE);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for start-up, a divisor
// change and a rejected zero divisor, followed by hand-written sequences for
// stopping, N=1 and reset while a divisor is pending.
// Observed bits, MSB first: {divided_clk, tick, div_err, running, div_ready}.
module tb_clk_div_ctrl;
    logic clk = 1'b0;
    logic reset;

    clk_div_ctrl_if #(.DIV_W(8)) bus ();

    clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       vld;
        logic [7:0] val;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic v,
                       input logic [7:0] val, input logic [4:0] exp, input string nm);
        vec_t t;
        t.rst = r; t.en = e; t.vld = v; t.val = val; t.exp = exp; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] val);
        reset         = r;
        bus.enable    = e;
        bus.div_valid = v;
        bus.div_value = val;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.divided_clk, bus.tick, bus.div_err, bus.running, bus.div_ready};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got clk/tick/err/run/rdy=%b expected %b at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s: clk/tick/err/run/rdy=%b", nm, act);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'd0);

        // Start-up with N=5, change to N=3 while high, then a zero divisor.
        add(1, 0, 0, 8'd0, 5'b00001, "reset_state");
        add(0, 1, 0, 8'd0, 5'b00011, "enter_run");
        add(0, 1, 0, 8'd0, 5'b00011, "n5_low_c1");
        add(0, 1, 0, 8'd0, 5'b00011, "n5_low_c2");
        add(0, 1, 0, 8'd0, 5'b00011, "n5_low_c3");
        add(0, 1, 0, 8'd0, 5'b00011, "n5_low_c4");
        add(0, 1, 0, 8'd0, 5'b11011, "n5_first_rise");
        add(0, 1, 1, 8'd3, 5'b10010, "offer3_pend");
        add(0, 1, 0, 8'd0, 5'b10010, "pend_high_c2");
        add(0, 1, 0, 8'd0, 5'b10010, "pend_high_c3");
        add(0, 1, 0, 8'd0, 5'b10010, "pend_high_c4");
        add(0, 1, 0, 8'd0, 5'b01011, "fall_applies3");
        add(0, 1, 0, 8'd0, 5'b00011, "n3_low_c1");
        add(0, 1, 0, 8'd0, 5'b00011, "n3_low_c2");
        add(0, 1, 0, 8'd0, 5'b11011, "n3_rise");
        add(0, 1, 0, 8'd0, 5'b10011, "n3_high_c1");
        add(0, 1, 0, 8'd0, 5'b10011, "n3_high_c2");
        add(0, 1, 0, 8'd0, 5'b01011, "n3_fall");
        add(0, 1, 1, 8'd0, 5'b00111, "zero_div_err");
        add(0, 1, 0, 8'd0, 5'b00011, "err_cleared");
        add(0, 1, 0, 8'd0, 5'b11011, "n3_kept_rise");

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].val);
            step();
            chk(vecs[i].name, vecs[i].exp);
        end

        // Stop in the high phase with counter=2: two more high cycles, then fall.
        drive(1, 0, 0, 8'd0); step(); chk("a_reset", 5'b00001);
        drive(0, 1, 0, 8'd0); step(); chk("a_run", 5'b00011);
        repeat (5) step();
        chk("a_rise", 5'b11011);
        repeat (2) step();
        chk("a_high_cnt2", 5'b10011);
        drive(0, 0, 0, 8'd0); step(); chk("a_stopping_high1", 5'b10010);
        step(); chk("a_stopping_high2", 5'b10010);
        step(); chk("a_park_fall", 5'b01001);
        step(); chk("a_idle", 5'b00001);

        // Stop while low: no toggle, no tick.
        drive(0, 1, 0, 8'd0); step(); chk("b_run", 5'b00011);
        step(); chk("b_low", 5'b00011);
        drive(0, 0, 0, 8'd0); step(); chk("b_stopping_low", 5'b00010);
        step(); chk("b_idle", 5'b00001);

        // N=1: toggles every clock, tick stays high; stop while high parks low.
        drive(0, 0, 1, 8'd1); step(); chk("c_load_n1", 5'b00001);
        drive(0, 1, 0, 8'd0); step(); chk("c_run", 5'b00011);
        for (int k = 1; k <= 5; k++) begin
            logic [4:0] e;
            e = {(k % 2 == 1), 4'b1011};
            step();
            chk($sformatf("c_n1_cycle%0d", k), e);
        end
        drive(0, 0, 0, 8'd0); step(); chk("c_park_low", 5'b01001);
        step(); chk("c_idle", 5'b00001);

        // Reset while a divisor is pending: output low at once, N back to 5.
        drive(1, 0, 0, 8'd0); step(); chk("d_reset", 5'b00001);
        drive(0, 1, 0, 8'd0); step(); chk("d_run", 5'b00011);
        repeat (5) step();
        chk("d_rise", 5'b11011);
        drive(0, 1, 1, 8'd3); step(); chk("d_pend", 5'b10010);
        drive(0, 1, 0, 8'd0); step(); chk("d_pend_high", 5'b10010);
        drive(1, 1, 0, 8'd0); step(); chk("d_reset_in_pend", 5'b00001);
        drive(0, 1, 0, 8'd0); step(); chk("d_rerun", 5'b00011);
        repeat (5) step();
        chk("d_rise_n5", 5'b11011);
        repeat (4) step();
        chk("d_high_n5", 5'b10011);
        step(); chk("d_fall_n5", 5'b01011);
        repeat (3) step();
        chk("d_no_stale_n3", 5'b00011);
        repeat (2) step();
        chk("d_rise_still_n5", 5'b11011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
